and2_pattern_checker: RTL and testbench

AND2_PATTERN_CHECKER -- requirements
Module: and2_pattern_checker

---
 rtl/and2_pattern_checker.sv | 141 ++++++++++++++
 tb/tb_and2_pattern_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/and2_pattern_checker.sv
// Built-in self-test pattern checker for a registered 2-input AND gate.
// An LFSR drives operands reg_a/reg_b. The expected AND result is delayed to
// line up with the device output dut_q. Mismatches are counted, and a
// pass/fail verdict is held once the run completes.
module and2_pattern_checker #(
    parameter int unsigned NUM_VECTORS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dut_q,
    output logic        reg_a,
    output logic        reg_b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] vec_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [15:0] LAST_VEC   = 16'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic               reg_a_q, reg_a_d;
    logic               reg_b_q, reg_b_d;
    logic               vec_vld_q, vec_vld_d;
    logic [LATENCY-1:0] vld_pipe_q, vld_pipe_d;
    logic [LATENCY-1:0] exp_pipe_q, exp_pipe_d;
    logic [15:0]        vec_cnt_q, vec_cnt_d;
    logic [15:0]        err_cnt_q, err_cnt_d;
    logic [3:0]         drain_cnt_q, drain_cnt_d;
    logic               mismatch;
    logic [15:0]        err_live;

    // The compare on the oldest pipeline entry is counted in the same cycle.
    // This lets the last result show up in the first DONE cycle.
    always_comb begin
        mismatch = vld_pipe_q[LATENCY-1] && (dut_q != exp_pipe_q[LATENCY-1]);
        err_live = (mismatch && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    // Next-state logic: sequencing, vector generation and the expected-result pipeline.
    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        reg_a_d     = 1'b0;
        reg_b_d     = 1'b0;
        vec_vld_d   = 1'b0;
        vec_cnt_d   = vec_cnt_q;
        err_cnt_d   = err_live;
        drain_cnt_d = drain_cnt_q;

        vld_pipe_d[0] = vec_vld_q;
        exp_pipe_d[0] = reg_a_q & reg_b_q;
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            exp_pipe_d[i] = exp_pipe_q[i-1];
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    lfsr_d    = LFSR_SEED;
                    vec_cnt_d = 16'd0;
                    err_cnt_d = 16'd0;
                end
            end
            S_RUN: begin
                reg_a_d   = lfsr_q[0];
                reg_b_d   = lfsr_q[1];
                vec_vld_d = 1'b1;
                lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                vec_cnt_d = vec_cnt_q + 16'd1;
                if (vec_cnt_q == LAST_VEC) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = 4'd0;
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    state_d = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset. Reset wins over start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            lfsr_q      <= LFSR_SEED;
            reg_a_q     <= 1'b0;
            reg_b_q     <= 1'b0;
            vec_vld_q   <= 1'b0;
            // NOTE: the pipeline is only LATENCY flops deep, so it is reset outright.
            // This keeps an abandoned run from leaking compares into the next one.
            vld_pipe_q  <= '0;
            exp_pipe_q  <= '0;
            vec_cnt_q   <= 16'd0;
            err_cnt_q   <= 16'd0;
            drain_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            reg_a_q     <= reg_a_d;
            reg_b_q     <= reg_b_d;
            vec_vld_q   <= vec_vld_d;
            vld_pipe_q  <= vld_pipe_d;
            exp_pipe_q  <= exp_pipe_d;
            vec_cnt_q   <= vec_cnt_d;
            err_cnt_q   <= err_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign reg_a     = reg_a_q;
    assign reg_b     = reg_b_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign pass      = done && (err_live == 16'd0);
    assign err_count = err_live;
    assign vec_count = vec_cnt_q;

endmodule

// File: tb/tb_and2_pattern_checker.sv
// Self-checking bench for and2_pattern_checker.
// A behavioural device model (a 2-stage registered AND, with selectable faults)
// feeds dut_q. A reference LFSR sequence and mismatch counts are derived from
// the arithmetic feedback rule.
module tb_and2_pattern_checker;

    localparam int N   = 256;
    localparam int LAT = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dut_q;
    logic        reg_a, reg_b, busy, done, pass;
    logic [15:0] err_count, vec_count;

    int tests = 0;
    int fails = 0;

    // Device model modes: 0 correct, 1 stuck-at-0, 2 inverted, 3 random flips.
    int   mode = 0;
    logic flip_next = 1'b0;
    logic s1 = 1'b0;
    logic s2 = 1'b0;

    bit ref_a [N];
    bit ref_b [N];
    int ones_cnt;

    and2_pattern_checker #(
        .NUM_VECTORS(N),
        .LATENCY    (LAT),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dut_q    (dut_q),
        .reg_a    (reg_a),
        .reg_b    (reg_b),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    // Two-stage registered AND gate standing in for the device under test.
    always @(posedge clk) begin
        s1 <= (reg_a & reg_b) ^ flip_next;
        s2 <= s1;
    end

    always_comb begin
        dut_q = s2;
        case (mode)
            1:       dut_q = 1'b0;
            2:       dut_q = ~s2;
            default: dut_q = s2;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Feedback is the parity of bits 15,13,12,10 shifted into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return 16'((x << 1) | 16'(^(x & 16'hB400)));
    endfunction

    // Issue one run and sample every cycle from the start-accept edge until DONE.
    task automatic do_run(input int m, input bit hold, output int busy_n, output int seq_bad,
                          output int pass_early, output int flips, output int vec0,
                          output int err0, output bit timed_out);
        logic [1:0] exp_v;
        mode = m;
        busy_n = 0; seq_bad = 0; pass_early = 0; flips = 0; vec0 = -1; err0 = -1;
        timed_out = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        if (!hold) #1 start = 1'b0;
        for (int cyc = 0; cyc < N + LAT + 20; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                vec0 = int'(vec_count);
                err0 = int'(err_count);
            end
            exp_v = (cyc >= 1 && cyc <= N) ? {ref_a[cyc-1], ref_b[cyc-1]} : 2'b00;
            if ({reg_a, reg_b} !== exp_v) seq_bad++;
            if (busy) busy_n++;
            if (busy && pass) pass_early++;
            if (mode == 3 && cyc >= 1 && cyc <= N) begin
                flip_next = ($urandom_range(0, 7) == 0);
                if (flip_next) flips++;
            end else begin
                flip_next = 1'b0;
            end
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        start = 1'b0;
        flip_next = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input int m, input bit hold, input bit check_clear);
        int busy_n, seq_bad, pass_early, flips, vec0, err0, exp_err;
        bit to;
        do_run(m, hold, busy_n, seq_bad, pass_early, flips, vec0, err0, to);
        case (m)
            1:       exp_err = ones_cnt;
            2:       exp_err = N;
            3:       exp_err = flips;
            default: exp_err = 0;
        endcase
        check({tag, "_timeout"},    64'(to), 64'd0);
        check({tag, "_busy_len"},   64'(busy_n), 64'(N + LAT));
        check({tag, "_sequence"},   64'(seq_bad), 64'd0);
        check({tag, "_pass_early"}, 64'(pass_early), 64'd0);
        check({tag, "_done"},       64'(done), 64'd1);
        check({tag, "_busy_done"},  64'(busy), 64'd0);
        check({tag, "_err"},        64'(err_count), 64'(exp_err));
        check({tag, "_vec"},        64'(vec_count), 64'(N));
        check({tag, "_pass"},       64'(pass), 64'(exp_err == 0));
        if (check_clear) begin
            check({tag, "_clr_vec"}, 64'(vec0), 64'd0);
            check({tag, "_clr_err"}, 64'(err0), 64'd0);
        end
        // Counters must hold while sitting in DONE.
        repeat ($urandom_range(1, 4)) @(negedge clk);
        check({tag, "_hold_err"}, 64'(err_count), 64'(exp_err));
        check({tag, "_hold_vec"}, 64'(vec_count), 64'(N));
    endtask

    initial begin
        logic [15:0] l;
        int bad;
        bit found;

        l = SEED;
        ones_cnt = 0;
        for (int i = 0; i < N; i++) begin
            ref_a[i] = l[0];
            ref_b[i] = l[1];
            if (l[0] && l[1]) ones_cnt++;
            l = lfsr_step(l);
        end

        // Reset held for two cycles, then idle with start low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {reg_a, reg_b, busy, done, pass, err_count, vec_count}, 64'd0);
        rst = 1'b0;
        bad = 0;
        repeat (20 + $urandom_range(0, 10)) begin
            @(negedge clk);
            if ({reg_a, reg_b, busy, done, pass, err_count, vec_count} !== 37'd0) bad++;
        end
        check("idle_quiet", 64'(bad), 64'd0);

        // Reset and start on the same edge: reset must win.
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_over_start", 64'(busy), 64'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);

        run_and_check("golden", 0, 1'b0, 1'b0);
        run_and_check("stuck0", 1, 1'b0, 1'b0);
        run_and_check("invert", 2, 1'b0, 1'b1);

        // Mid-run reset at vec_count==100, then rerun with start held high.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (vec_count == 16'd100) begin
                found = 1'b1;
                break;
            end
        end
        check("midrun_reach100", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_outs", {reg_a, reg_b, busy, done, pass, err_count, vec_count}, 64'd0);
        rst = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        run_and_check("held_start", 0, 1'b1, 1'b1);

        run_and_check("rand_flip", 3, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
